// File: rtl/chebyshev_computation_v2.sv
// ---------------------------------------------------------------------------
// chebyshev_computation_v2
//
// Streaming fixed-point Chebyshev term stage: data_out = c * T2(x), where
// T2(x) = 2x^2 - 1. The datapath is fully pipelined and accepts one sample per
// clock. Inputs sampled on rising edge k appear on data_out after edge k+2.
// All products are full precision, so nothing is rounded or saturated.
//
// Parameters
//   WL        word length of data_in,  signed Q0.(WL-1)
//   CL        word length of coeff_in, signed Q1.(CL-2)
//   WIDENING  extra sign-extension bits on data_out
//   OUT       derived output width, 2*WL + CL + WIDENING
//
// Ports
//   clock     rising-edge clock for all registers
//   resetn    asynchronous reset, ACTIVE HIGH despite its name
//   data_in   sample x,      WL bits signed
//   coeff_in  coefficient c, CL bits signed
//   data_out  c*(2x^2-1),    OUT bits signed, 2(WL-1)+(CL-2) fraction bits
// ---------------------------------------------------------------------------
module chebyshev_computation_v2 #(
   parameter  int WL       = 4,
   parameter  int CL       = 4,
   parameter  int WIDENING = 0,
   localparam int OUT      = 2*WL + CL + WIDENING
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic signed [WL-1:0]  data_in,
   input  logic signed [CL-1:0]  coeff_in,
   output logic signed [OUT-1:0] data_out
);

   localparam int TW = 2*WL;        // T2 width: 2 integer bits, 2(WL-1) fraction
   localparam int PW = 2*WL + CL;   // full-precision product width

   // 1.0 aligned to the 2(WL-1) fraction bits of x*x.
   localparam logic signed [TW-1:0] ONE = TW'(1) << (2*(WL-1));

   // Stage registers and their next-state values.
   logic signed [WL-1:0]  x_q,        x_d;
   logic signed [CL-1:0]  c_q,        c_d;
   logic signed [TW-1:0]  t2_q,       t2_d;
   logic signed [CL-1:0]  c2_q,       c2_d;
   logic signed [OUT-1:0] data_out_q, data_out_d;

   // Operands widened up front so every product is computed at its
   // destination width and stays exact.
   logic signed [TW-1:0] x_ext;
   logic signed [TW-1:0] sq;
   logic signed [PW-1:0] t2_ext;
   logic signed [PW-1:0] c2_ext;
   logic signed [PW-1:0] prod;

   always_comb begin
      // S1: capture the raw inputs.
      x_d    = data_in;
      c_d    = coeff_in;

      // S2: T2 = 2x^2 - 1. For x = -1 the shift wraps past the sign bit, but
      // the subtraction brings the modular result back to exactly +1.0.
      x_ext  = TW'(x_q);
      sq     = x_ext * x_ext;
      t2_d   = (sq <<< 1) - ONE;
      c2_d   = c_q;              // keeps the coefficient aligned with t2

      // S3: exact product, then sign-extend into the guard bits.
      t2_ext     = PW'(t2_q);
      c2_ext     = PW'(c2_q);
      prod       = t2_ext * c2_ext;
      data_out_d = OUT'(prod);
   end

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the previous stage's value from before the edge.
   always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
         x_q        <= '0;
         c_q        <= '0;
         t2_q       <= '0;
         c2_q       <= '0;
         data_out_q <= '0;
      end else begin
         x_q        <= x_d;
         c_q        <= c_d;
         t2_q       <= t2_d;
         c2_q       <= c2_d;
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_chebyshev_computation_v2.sv
// ---------------------------------------------------------------------------
// tb_chebyshev_computation_v2
//
// Drives two instances of chebyshev_computation_v2 in parallel (WIDENING = 0
// and WIDENING = 2) from the same inputs. Every clock the expected result for
// the current inputs is pushed onto a queue; after each rising edge the
// oldest entry is popped and compared with both outputs. An asynchronous reset
// clears the queue and reloads the two zero results held in the pipeline.
// ---------------------------------------------------------------------------
module tb_chebyshev_computation_v2;

   localparam int WL    = 4;
   localparam int CL    = 4;
   localparam int OUT_N = 2*WL + CL;       // 12
   localparam int OUT_W = 2*WL + CL + 2;   // 14
   localparam int ONE_I = 1 << (2*(WL-1)); // 64

   logic                    clock;
   logic                    resetn;
   logic signed [WL-1:0]    data_in;
   logic signed [CL-1:0]    coeff_in;
   logic signed [OUT_N-1:0] data_out_n;
   logic signed [OUT_W-1:0] data_out_w;

   int tests_run = 0;
   int tests_failed = 0;
   int exp_q[$];

   chebyshev_computation_v2 #(.WL(WL), .CL(CL), .WIDENING(0)) dut_n (
      .clock    (clock),
      .resetn   (resetn),
      .data_in  (data_in),
      .coeff_in (coeff_in),
      .data_out (data_out_n)
   );

   chebyshev_computation_v2 #(.WL(WL), .CL(CL), .WIDENING(2)) dut_w (
      .clock    (clock),
      .resetn   (resetn),
      .data_in  (data_in),
      .coeff_in (coeff_in),
      .data_out (data_out_w)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Reference: integer arithmetic on the fixed-point codes.
   // x has WL-1 fraction bits, so 2x^2 - 1 in 2(WL-1)-fraction units is
   // 2*xi*xi - 2^(2(WL-1)); multiplying by the coefficient code adds CL-2 bits.
   function automatic int model(input logic signed [WL-1:0] x,
                                input logic signed [CL-1:0] c);
      int xi;
      int ci;
      xi = int'(x);
      ci = int'(c);
      return (2*xi*xi - ONE_I) * ci;
   endfunction

   task automatic check(input string tag,
                        input logic signed [15:0] observed,
                        input logic signed [15:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %0d (%h) expected %0d (%h)",
                tag, observed, observed, expected, expected);
      end
   endtask

   task automatic check_outputs(input string tag, input int e);
      check({tag, "/w0"}, 16'(data_out_n), 16'(e));
      check({tag, "/w2"}, 16'(data_out_w), 16'(e));
   endtask

   // One clock: record the expected result of the inputs about to be
   // sampled, then compare the result that leaves the pipeline on this edge.
   task automatic tick(input string tag);
      int e;
      exp_q.push_back(model(data_in, coeff_in));
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s: observed empty scoreboard expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         check_outputs(tag, e);
      end
   endtask

   task automatic drive(input logic signed [WL-1:0] x,
                        input logic signed [CL-1:0] c);
      data_in  = x;
      coeff_in = c;
   endtask

   // Asynchronous reset pulse placed between clock edges. Called 1 time unit
   // after a rising edge; outputs must clear before any further edge.
   task automatic async_reset(input string tag);
      #2;
      resetn = 1'b1;
      #1;
      check_outputs({tag, "/clear"}, 0);
      #2;
      resetn = 1'b0;
      exp_q.delete();
      // The cleared pipeline holds two stages that each produce 0.
      exp_q.push_back(0);
      exp_q.push_back(0);
   endtask

   initial begin
      resetn = 1'b1;
      drive(4'sb0_011, 4'sb01_01);   // nonzero inputs must not leak through reset
      @(posedge clock);
      #1;
      check_outputs("reset_hold0", 0);
      @(posedge clock);
      #1;
      check_outputs("reset_hold1", 0);
      #4;
      resetn = 1'b0;
      exp_q.push_back(0);
      exp_q.push_back(0);

      // Test 1: async pulse between edges, then the pipeline refills.
      drive(4'sb0_001, 4'sb01_01);
      tick("post_reset_a");          // zero from flushed pipeline
      async_reset("t1");
      tick("t1_fill0");              // 0
      tick("t1_fill1");              // 0
      tick("t1_first");              // first post-reset sample (-310)

      // Test 2: x = 0, c = 0.5 -> -128
      drive(4'sb0_000, 4'sb00_10);
      tick("t2_a");
      tick("t2_b");
      tick("t2_c");
      check_outputs("t2_direct", -128);

      // Test 3: x = 0.125, c = 1.25 -> -310
      drive(4'sb0_001, 4'sb01_01);
      tick("t3_a");
      tick("t3_b");
      tick("t3_c");
      check_outputs("t3_direct", -310);

      // Test 4: x = 0.875, c = 0 -> 0
      drive(4'sb0_111, 4'sb00_00);
      tick("t4_a");
      tick("t4_b");
      tick("t4_c");
      check_outputs("t4_direct", 0);

      // Test 5: x = -1, c = 1.75 -> 448; then c = -2 -> -512
      drive(4'sb1_000, 4'sb01_11);
      tick("t5a_a");
      tick("t5a_b");
      tick("t5a_c");
      check_outputs("t5a_direct", 448);
      drive(4'sb1_000, 4'sb10_00);
      tick("t5b_a");
      tick("t5b_b");
      tick("t5b_c");
      check_outputs("t5b_direct", -512);

      // Test 6: back-to-back samples, one result per cycle in order.
      drive(4'sb0_000, 4'sb00_10);  tick("t6_s0");
      drive(4'sb0_001, 4'sb01_01);  tick("t6_s1");
      drive(4'sb0_111, 4'sb00_00);  tick("t6_s2");   // out: -128
      check_outputs("t6_order0", -128);
      drive(4'sb1_000, 4'sb01_11);  tick("t6_s3");   // out: -310
      check_outputs("t6_order1", -310);
      drive(4'sb1_000, 4'sb10_00);  tick("t6_s4");   // out: 0
      check_outputs("t6_order2", 0);
      drive(4'sb0_101, 4'sb11_01);  tick("t6_s5");   // out: 448
      check_outputs("t6_order3", 448);
      drive(4'sb1_011, 4'sb01_10);  tick("t6_s6");   // out: -512
      check_outputs("t6_order4", -512);

      // Mid-stream reset with two samples still in flight.
      async_reset("t6_mid");
      drive(4'sb1_101, 4'sb10_11);
      tick("t6_post0");
      tick("t6_post1");
      tick("t6_post2");

      // A short run of pseudo-random samples through the same scoreboard.
      for (int i = 0; i < 16; i++) begin
         drive(WL'($urandom_range(0, (1 << WL) - 1)),
               CL'($urandom_range(0, (1 << CL) - 1)));
         tick("rand");
      end
      drive(4'sb0_000, 4'sb00_00);
      tick("drain0");
      tick("drain1");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/chebyshev_computation_v2.md
Name: chebyshev_computation_v2

Overview:
Streaming fixed-point Chebyshev term evaluator. Each cycle it takes a sample x and a coefficient c, and produces y = c·T2(x), where T2(x) = 2x² − 1. It is a fully pipelined datapath slice used as one term stage of a Chebyshev polynomial approximation. There is no handshake: one result per clock, fixed latency.

Parameters:
WL, 4, word length of data_in; signed Q0.(WL−1), 1 sign bit and WL−1 fraction bits, range [−1, 1).
CL, 4, word length of coeff_in; signed Q1.(CL−2), 2 integer bits including sign and CL−2 fraction bits.
WIDENING, 0, extra guard bits added at the MSB of data_out; sign-extension only, value unchanged.
Derived, not overridable: OUT = 2·WL + CL + WIDENING.

Ports:
clock  input  1  rising-edge clock for all registers.
resetn  input  1  asynchronous, active-high reset (1 = reset asserted) despite the name; clears all pipeline registers.
data_in  input  WL  signed sample x, Q0.(WL−1).
coeff_in  input  CL  signed coefficient c, Q1.(CL−2).
data_out  output  OUT  signed result c·(2x²−1), 2·(WL−1)+(CL−2) fraction bits.

Behaviour:
- Pipeline stages, all registers clear to 0 asynchronously while resetn = 1:
  - S1: register data_in → x_r and coeff_in → c_r.
  - S2: compute sq = x_r·x_r as a 2·WL signed full-precision product with 2(WL−1) fraction bits. Compute t2 = (sq << 1) − 1.0, where 1.0 = 2^(2(WL−1)), in 2·WL signed bits. Register t2 → t2_r and c_r → c_d (coefficient delay keeps alignment).
  - S3: p = t2_r·c_d, a signed full-precision product of 2·WL + CL bits. Sign-extend by WIDENING bits and register → data_out.
- Latency: inputs sampled at rising edge k appear on data_out after rising edge k+2. Throughput is 1 per cycle.
- Width and overflow:
  - t2 lies in [−1, 1]; x = −1 gives t2 = +1, which is exactly representable in 2·WL bits (2 integer bits).
  - |p| ≤ 2, so no saturation or rounding is needed anywhere. All products are exact and there is no truncation.
- Reset:
  - data_out = 0 during reset and for the two edges after release, until the first post-reset sample propagates.
  - Reset asserted mid-stream discards all in-flight samples immediately, without waiting for a clock.
- data_out is driven directly from the S3 register; there is no combinational path from inputs to output.
- Back-to-back changing inputs every cycle must each yield their own result; there is no cross-sample interaction.

Test Plan:
(defaults WL=4, CL=4, WIDENING=0, OUT=12; data_out has 8 fraction bits)
1. Pulse resetn=1 asynchronously between clock edges → data_out = 0x000 immediately and held; the first sample after release emerges after 2 further rising edges.
2. data_in=4'b0_000 (0), coeff_in=4'b00_10 (0.5) → T2 = −1, data_out = −128 = 12'hF80 two edges later.
3. data_in=4'b0_001 (0.125), coeff_in=4'b01_01 (1.25) → −1.2109375, data_out = −310 = 12'hECA.
4. data_in=4'b0_111 (0.875), coeff_in=4'b00_00 → data_out = 12'h000.
5. data_in=4'b1_000 (−1), coeff_in=4'b01_11 (1.75) → T2 = +1, data_out = 448 = 12'h1C0. Then coeff_in=4'b10_00 (−2) with the same x → data_out = −512 = 12'hE00, the extreme corner with no overflow.
6. Apply scenarios 2–5 on consecutive cycles with WIDENING=2 (OUT=14) → identical values, sign-extended, one per cycle in order; assert resetn mid-stream and check the outputs clear to 0 at once.
